// File: rtl/prn_code_pkg.sv
`timescale 1ns/1ps
// prn_code_pkg: code lengths, LFSR widths, seeds, feedback masks and the
// ICD G2 phase-select tap table shared by the PRN generator files.
package prn_code_pkg;

    localparam int unsigned GPS_LEN = 1023;
    localparam int unsigned GLO_LEN = 511;
    localparam int unsigned GPS_W   = 10;
    localparam int unsigned GLO_W   = 9;

    localparam logic [GPS_W-1:0] GPS_SEED = '1;
    localparam logic [GLO_W-1:0] GLO_SEED = '1;
    localparam logic [GPS_W-1:0] GPS_LAST = 10'(GPS_LEN - 1);
    localparam logic [GLO_W-1:0] GLO_LAST = 9'(GLO_LEN - 1);

    // Bit i holds LFSR stage i+1; masks select the feedback stages.
    localparam logic [GPS_W-1:0] G1_FB_MASK  = 10'b10_0000_0100;
    localparam logic [GPS_W-1:0] G2_FB_MASK  = 10'b11_1010_0110;
    localparam logic [GLO_W-1:0] GLO_FB_MASK = 9'b1_0001_0000;
    localparam int unsigned      GLO_CHIP_BIT = 6;

    localparam logic [5:0] PRN_MAX = 6'd32;

    typedef struct packed {
        logic [3:0] s1;
        logic [3:0] s2;
    } tap_pair_t;

    // Entry n holds the G2 stage pair for PRN n+1.
    localparam tap_pair_t G2_TAPS [32] = '{
        8'h26, 8'h37, 8'h48, 8'h59, 8'h19, 8'h2A, 8'h18, 8'h29,
        8'h3A, 8'h23, 8'h34, 8'h56, 8'h67, 8'h78, 8'h89, 8'h9A,
        8'h14, 8'h25, 8'h36, 8'h47, 8'h58, 8'h69, 8'h13, 8'h46,
        8'h57, 8'h68, 8'h79, 8'h8A, 8'h16, 8'h27, 8'h38, 8'h49
    };

    function automatic logic gps_chip(input logic [GPS_W-1:0] g1,
                                      input logic [GPS_W-1:0] g2,
                                      input logic [4:0]       tap_sel);
        tap_pair_t tp;
        tp = G2_TAPS[tap_sel];
        return g1[GPS_W-1] ^ g2[tp.s1 - 4'd1] ^ g2[tp.s2 - 4'd1];
    endfunction

endpackage

// File: rtl/prn_code_gen_if.sv
`timescale 1ns/1ps
// prn_code_gen_if: chip-clock, PRN-load and code-output signals of prn_code_gen.
interface prn_code_gen_if;
    import prn_code_pkg::*;

    logic             in_clock_GLONASS;
    logic             in_clock_GPS;
    logic [5:0]       in_prn;
    logic             in_prn_load;
    logic             out_chip_GPS;
    logic             out_chip_GLONASS;
    logic [GPS_W-1:0] out_idx_GPS;
    logic [GLO_W-1:0] out_idx_GLONASS;
    logic             out_epoch_GPS;
    logic             out_epoch_GLONASS;
    logic             out_prn_err;

    modport master (
        output in_clock_GLONASS, in_clock_GPS, in_prn, in_prn_load,
        input  out_chip_GPS, out_chip_GLONASS, out_idx_GPS, out_idx_GLONASS,
               out_epoch_GPS, out_epoch_GLONASS, out_prn_err
    );

    modport slave (
        input  in_clock_GLONASS, in_clock_GPS, in_prn, in_prn_load,
        output out_chip_GPS, out_chip_GLONASS, out_idx_GPS, out_idx_GLONASS,
               out_epoch_GPS, out_epoch_GLONASS, out_prn_err
    );

endinterface

// File: rtl/prn_rise_det.sv
`timescale 1ns/1ps
// prn_rise_det: samples a divided chip clock as data and emits a registered
// one-cycle strobe for each 0->1 transition.
module prn_rise_det (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic rise_o
);

    logic samp_q;
    logic rise_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            samp_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            samp_q <= raw_i;
            rise_q <= raw_i & ~samp_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/prn_code_gen.sv
`timescale 1ns/1ps
// prn_code_gen: GPS C/A Gold-code generator with PRN load, plus an optional
// GLONASS ranging-code LFSR built only when PRN_GLONASS_EN is defined.
module prn_code_gen #(
    parameter logic [5:0] PRN_DEFAULT = 6'd1,
    parameter logic [8:0] GLO_INIT    = 9'h1FF
) (
    input  logic          in_clock,
    input  logic          in_reset,
    prn_code_gen_if.slave bus
);
    import prn_code_pkg::*;

    logic             gps_adv;
    logic             load_ok;
    logic [GPS_W-1:0] g1_q, g1_d, g2_q, g2_d;
    logic [GPS_W-1:0] gidx_q, gidx_d;
    logic [4:0]       tap_q, tap_d;
    logic             gchip_q, gchip_d;
    logic             gep_q, gep_d;
    logic             err_q, err_d;

    prn_rise_det u_gps_det (
        .clk_i  (in_clock),
        .rst_i  (in_reset),
        .raw_i  (bus.in_clock_GPS),
        .rise_o (gps_adv)
    );

    // A valid load overrides a same-cycle advance; a rejected load does not.
    always_comb begin
        g1_d    = g1_q;
        g2_d    = g2_q;
        gidx_d  = gidx_q;
        tap_d   = tap_q;
        gep_d   = 1'b0;
        err_d   = 1'b0;
        load_ok = bus.in_prn_load && (bus.in_prn != '0) && (bus.in_prn <= PRN_MAX);
        if (load_ok) begin
            tap_d  = bus.in_prn[4:0] - 5'd1;
            g1_d   = GPS_SEED;
            g2_d   = GPS_SEED;
            gidx_d = '0;
        end else begin
            err_d = bus.in_prn_load;
            if (gps_adv) begin
                if (gidx_q == GPS_LAST) begin
                    g1_d   = GPS_SEED;
                    g2_d   = GPS_SEED;
                    gidx_d = '0;
                    gep_d  = 1'b1;
                end else begin
                    g1_d   = {g1_q[GPS_W-2:0], ^(g1_q & G1_FB_MASK)};
                    g2_d   = {g2_q[GPS_W-2:0], ^(g2_q & G2_FB_MASK)};
                    gidx_d = gidx_q + 10'd1;
                end
            end
        end
        gchip_d = gps_chip(g1_d, g2_d, tap_d);
    end

    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            g1_q    <= GPS_SEED;
            g2_q    <= GPS_SEED;
            gidx_q  <= '0;
            tap_q   <= PRN_DEFAULT[4:0] - 5'd1;
            gchip_q <= gps_chip(GPS_SEED, GPS_SEED, PRN_DEFAULT[4:0] - 5'd1);
            gep_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            g1_q    <= g1_d;
            g2_q    <= g2_d;
            gidx_q  <= gidx_d;
            tap_q   <= tap_d;
            gchip_q <= gchip_d;
            gep_q   <= gep_d;
            err_q   <= err_d;
        end
    end

    assign bus.out_chip_GPS  = gchip_q;
    assign bus.out_idx_GPS   = gidx_q;
    assign bus.out_epoch_GPS = gep_q;
    assign bus.out_prn_err   = err_q;

`ifdef PRN_GLONASS_EN
    logic             glo_adv;
    logic [GLO_W-1:0] glo_q, glo_d;
    logic [GLO_W-1:0] lidx_q, lidx_d;
    logic             lchip_q, lchip_d;
    logic             lep_q, lep_d;

    prn_rise_det u_glo_det (
        .clk_i  (in_clock),
        .rst_i  (in_reset),
        .raw_i  (bus.in_clock_GLONASS),
        .rise_o (glo_adv)
    );

    always_comb begin
        glo_d  = glo_q;
        lidx_d = lidx_q;
        lep_d  = 1'b0;
        if (glo_adv) begin
            if (lidx_q == GLO_LAST) begin
                glo_d  = GLO_INIT;
                lidx_d = '0;
                lep_d  = 1'b1;
            end else begin
                glo_d  = {glo_q[GLO_W-2:0], ^(glo_q & GLO_FB_MASK)};
                lidx_d = lidx_q + 9'd1;
            end
        end
        lchip_d = glo_d[GLO_CHIP_BIT];
    end

    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            glo_q   <= GLO_INIT;
            lidx_q  <= '0;
            lchip_q <= GLO_INIT[GLO_CHIP_BIT];
            lep_q   <= 1'b0;
        end else begin
            glo_q   <= glo_d;
            lidx_q  <= lidx_d;
            lchip_q <= lchip_d;
            lep_q   <= lep_d;
        end
    end

    assign bus.out_chip_GLONASS  = lchip_q;
    assign bus.out_idx_GLONASS   = lidx_q;
    assign bus.out_epoch_GLONASS = lep_q;
`else
    assign bus.out_chip_GLONASS  = 1'b0;
    assign bus.out_idx_GLONASS   = '0;
    assign bus.out_epoch_GLONASS = 1'b0;
`endif

endmodule

// File: tb/tb_prn_code_gen.sv
`timescale 1ns/1ps
// tb_prn_code_gen: directed + random stimulus; an index-level reference model
// feeds a per-cycle scoreboard queue that a separate monitor drains.
module tb_prn_code_gen;

`ifdef PRN_GLONASS_EN
    localparam bit GLO_EN = 1'b1;
`else
    localparam bit GLO_EN = 1'b0;
`endif
    localparam logic [5:0] PRN_DEF  = 6'd1;
    localparam logic [8:0] GLO_SEED = 9'h1FF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prn_code_gen_if bus ();

    prn_code_gen #(
        .PRN_DEFAULT (PRN_DEF),
        .GLO_INIT    (GLO_SEED)
    ) dut (
        .in_clock (clk),
        .in_reset (rst),
        .bus      (bus)
    );

    typedef struct packed {
        logic [9:0] gidx;
        logic       gchip;
        logic       gep;
        logic       err;
        logic [8:0] lidx;
        logic       lchip;
        logic       lep;
    } snap_t;

    snap_t sb [$];
    int total = 0;
    int bad   = 0;
    int ep_g_cnt = 0;
    int ep_l_cnt = 0;
    int err_cnt  = 0;

    bit gps_seq [1:32][0:1022];
    bit glo_seq [0:510];

    // ICD-GPS-200 G2 phase-select stage pairs, PRN 1..32
    int tap1 [1:32] = '{2,3,4,5,1,2,1,2,3,2,3,5,6,7,8,9,1,2,3,4,5,6,1,4,5,6,7,8,1,2,3,4};
    int tap2 [1:32] = '{6,7,8,9,9,10,8,9,10,3,4,6,7,8,9,10,4,5,6,7,8,9,3,6,7,8,9,10,6,7,8,9};

    function automatic void chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, exp);
        end
    endfunction

    // Code sequences from the polynomial recurrences on the output bit stream.
    task automatic build_seqs();
        bit g1 [0:1039];
        bit g2 [0:1039];
        bit gl [0:519];
        for (int n = 0; n < 10; n++) begin
            g1[n] = 1'b1;
            g2[n] = 1'b1;
        end
        for (int n = 0; n + 10 < 1040; n++) begin
            g1[n+10] = g1[n+7] ^ g1[n];
            g2[n+10] = g2[n+8] ^ g2[n+7] ^ g2[n+4] ^ g2[n+2] ^ g2[n+1] ^ g2[n];
        end
        for (int p = 1; p <= 32; p++)
            for (int n = 0; n < 1023; n++)
                gps_seq[p][n] = g1[n] ^ g2[n+10-tap1[p]] ^ g2[n+10-tap2[p]];
        for (int k = 0; k < 9; k++) gl[k] = GLO_SEED[8-k];
        for (int n = 0; n + 9 < 520; n++) gl[n+9] = gl[n+4] ^ gl[n];
        for (int n = 0; n < 511; n++) glo_seq[n] = gl[n+2];
    endtask

    // Reference model: PRN, indices and pending edge strobes, updated per clock edge.
    int m_prn, m_gidx, m_lidx;
    bit m_grise, m_gprev, m_lrise, m_lprev, m_gep, m_lep, m_err, m_ok;

    initial begin
        snap_t e;
        build_seqs();
        forever begin
            @(posedge clk);
            m_gep = 1'b0; m_lep = 1'b0; m_err = 1'b0; m_ok = 1'b0;
            if (rst) begin
                m_prn = int'(PRN_DEF); m_gidx = 0; m_lidx = 0;
                m_grise = 1'b0; m_gprev = 1'b0; m_lrise = 1'b0; m_lprev = 1'b0;
            end else begin
                if (bus.in_prn_load) begin
                    if (bus.in_prn >= 6'd1 && bus.in_prn <= 6'd32) begin
                        m_prn = int'(bus.in_prn); m_gidx = 0; m_ok = 1'b1;
                    end else m_err = 1'b1;
                end
                if (m_grise && !m_ok) begin
                    m_gidx = (m_gidx + 1) % 1023;
                    m_gep  = (m_gidx == 0);
                end
                if (GLO_EN && m_lrise) begin
                    m_lidx = (m_lidx + 1) % 511;
                    m_lep  = (m_lidx == 0);
                end
                m_grise = bus.in_clock_GPS && !m_gprev;     m_gprev = bus.in_clock_GPS;
                m_lrise = bus.in_clock_GLONASS && !m_lprev; m_lprev = bus.in_clock_GLONASS;
            end
            e.gidx  = 10'(m_gidx);
            e.gchip = gps_seq[m_prn][m_gidx];
            e.gep   = m_gep;
            e.err   = m_err;
            e.lidx  = GLO_EN ? 9'(m_lidx) : 9'd0;
            e.lchip = GLO_EN ? glo_seq[m_lidx] : 1'b0;
            e.lep   = m_lep;
            sb.push_back(e);
        end
    end

    // Monitor: pops one expected snapshot per presented output cycle.
    initial begin
        snap_t e;
        forever begin
            @(negedge clk);
            ep_g_cnt += int'(bus.out_epoch_GPS);
            ep_l_cnt += int'(bus.out_epoch_GLONASS);
            err_cnt  += int'(bus.out_prn_err);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("gps_idx",   int'(bus.out_idx_GPS),       int'(e.gidx));
                chk("gps_chip",  int'(bus.out_chip_GPS),      int'(e.gchip));
                chk("gps_epoch", int'(bus.out_epoch_GPS),     int'(e.gep));
                chk("prn_err",   int'(bus.out_prn_err),       int'(e.err));
                chk("glo_idx",   int'(bus.out_idx_GLONASS),   int'(e.lidx));
                chk("glo_chip",  int'(bus.out_chip_GLONASS),  int'(e.lchip));
                chk("glo_epoch", int'(bus.out_epoch_GLONASS), int'(e.lep));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic gps_pulse(input int half);
        bus.in_clock_GPS = 1'b1; tick(half);
        bus.in_clock_GPS = 1'b0; tick(half);
    endtask

    task automatic glo_pulse(input int hi, input int lo);
        bus.in_clock_GLONASS = 1'b1; tick(hi);
        bus.in_clock_GLONASS = 1'b0; tick(lo);
    endtask

    task automatic both_pulse();
        bus.in_clock_GPS = 1'b1; bus.in_clock_GLONASS = 1'b1; tick(2);
        bus.in_clock_GPS = 1'b0; bus.in_clock_GLONASS = 1'b0; tick(2);
    endtask

    // Load strobe lands on the same edge that applies a pending GPS advance.
    task automatic load_on_advance(input logic [5:0] prn);
        bus.in_clock_GPS = 1'b1; tick(1);
        bus.in_prn = prn; bus.in_prn_load = 1'b1; tick(1);
        bus.in_prn_load = 1'b0; tick(1);
        bus.in_clock_GPS = 1'b0; tick(2);
    endtask

    initial begin
        #2_000_000;
        bad++;
        $display("FAIL watchdog: got timeout, want completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int ones, first, base_ep, base_err;
        bus.in_clock_GPS = 1'b0; bus.in_clock_GLONASS = 1'b0;
        bus.in_prn = 6'd0; bus.in_prn_load = 1'b0;
        rst = 1'b1; tick(3); rst = 1'b0; tick(2);
        chk("reset_idx",  int'(bus.out_idx_GPS), 0);
        chk("reset_chip", int'(bus.out_chip_GPS), 1);

        // One full GPS period: 10 chips at period 50, the rest fast.
        ones = 0; first = 0; base_ep = ep_g_cnt;
        for (int n = 0; n < 1023; n++) begin
            if (n < 10) first = (first << 1) | int'(bus.out_chip_GPS);
            ones += int'(bus.out_chip_GPS);
            if (n == 1022) chk("gps_no_early_epoch", ep_g_cnt - base_ep, 0);
            gps_pulse(n < 10 ? 25 : 2);
        end
        chk("gps_first10", first, 'o1440);
        chk("gps_ones",    ones, 512);
        chk("gps_epochs",  ep_g_cnt - base_ep, 1);
        chk("gps_wrap_idx", int'(bus.out_idx_GPS), 0);

`ifdef PRN_GLONASS_EN
        ones = 0; first = 0; base_ep = ep_l_cnt;
        for (int n = 0; n < 511; n++) begin
            if (n < 8) first = (first << 1) | int'(bus.out_chip_GLONASS);
            ones += int'(bus.out_chip_GLONASS);
            glo_pulse(n < 8 ? 12 : 2, n < 8 ? 13 : 2);
        end
        chk("glo_first8",   first, 8'b1111_1110);
        chk("glo_ones",     ones, 256);
        chk("glo_epochs",   ep_l_cnt - base_ep, 1);
        chk("glo_wrap_idx", int'(bus.out_idx_GLONASS), 0);
`else
        for (int n = 0; n < 40; n++) begin
            glo_pulse(2, 2);
            chk("glo_off", int'({bus.out_chip_GLONASS, bus.out_idx_GLONASS, bus.out_epoch_GLONASS}), 0);
        end
        chk("glo_off_epochs", ep_l_cnt, 0);
`endif

        // Rejected loads: error pulses, stream keeps advancing.
        base_err = err_cnt;
        repeat (3) gps_pulse(2);
        load_on_advance(6'd0);
        bus.in_prn = 6'd33; bus.in_prn_load = 1'b1; tick(1);
        bus.in_prn_load = 1'b0; tick(1);
        gps_pulse(2);
        chk("bad_load_errs", err_cnt - base_err, 2);
        chk("bad_load_idx",  int'(bus.out_idx_GPS), 5);

        // Valid load coincident with an advance: index restarts, advance dropped.
        load_on_advance(6'd5);
        chk("load5_idx",  int'(bus.out_idx_GPS), 0);
        chk("load5_chip", int'(bus.out_chip_GPS), 1);
        chk("load5_errs", err_cnt - base_err, 2);
        repeat (3) both_pulse();
        chk("both_idx", int'(bus.out_idx_GPS), 3);

        // Reset mid-code at index 700.
        repeat (697) gps_pulse(2);
        chk("pre_reset_idx", int'(bus.out_idx_GPS), 700);
        base_ep = ep_g_cnt;
        rst = 1'b1; tick(1); rst = 1'b0;
        chk("mid_reset_idx", int'(bus.out_idx_GPS), 0);
        tick(1);
        chk("mid_reset_epoch", ep_g_cnt - base_ep, 0);
        first = 0;
        for (int n = 0; n < 10; n++) begin
            first = (first << 1) | int'(bus.out_chip_GPS);
            gps_pulse(2);
        end
        chk("prn_default_after_reset", first, 'o1440);

        // Random chip clocks, loads and occasional resets.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 2) == 0) bus.in_clock_GPS = ~bus.in_clock_GPS;
            if ($urandom_range(0, 3) == 0) bus.in_clock_GLONASS = ~bus.in_clock_GLONASS;
            bus.in_prn      = 6'($urandom_range(0, 40));
            bus.in_prn_load = ($urandom_range(0, 29) == 0);
            rst             = ($urandom_range(0, 599) == 0);
            tick(1);
        end
        bus.in_prn_load = 1'b0; rst = 1'b0;
        bus.in_clock_GPS = 1'b0; bus.in_clock_GLONASS = 1'b0;
        tick(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prn_code_gen.md
PRN_CODE_GEN -- requirements
Module: prn_code_gen

Interface
REQ-001 SHALL have parameter PRN_DEFAULT, 6'd1, GPS PRN selected after reset (1..32).
REQ-002 SHALL have parameter GLO_INIT, 9'h1FF, GLONASS LFSR seed after reset.
REQ-003 SHALL have port in_clock  input  1  sole clock, all logic on its rising edge.
REQ-004 SHALL have port in_reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_clock_GLONASS  input  1  divided GLONASS chip clock, sampled as data.
REQ-006 SHALL have port in_clock_GPS  input  1  divided GPS chip clock, sampled as data.
REQ-007 SHALL have port in_prn  input  6  GPS PRN number for load.
REQ-008 SHALL have port in_prn_load  input  1  one-cycle strobe, latch in_prn.
REQ-009 SHALL have port out_chip_GPS  output  1  current C/A chip.
REQ-010 SHALL have port out_chip_GLONASS  output  1  current GLONASS ranging chip.
REQ-011 SHALL have port out_idx_GPS  output  10  current GPS chip index 0..1022.
REQ-012 SHALL have port out_idx_GLONASS  output  9  current GLONASS chip index 0..510.
REQ-013 SHALL have port out_epoch_GPS  output  1  one-cycle pulse on code wrap.
REQ-014 SHALL have port out_epoch_GLONASS  output  1  one-cycle pulse on code wrap.
REQ-015 SHALL have port out_prn_err  output  1  one-cycle pulse on rejected load.

Function
REQ-016 SHALL register each chip-clock input once; chip advance = previous sample 0, current sample 1 (one advance per rising edge, 1-cycle detect latency).
REQ-017 GPS: G1 = 1+x^3+x^10, G2 = 1+x^2+x^3+x^6+x^8+x^9+x^10, both seeded all-ones; chip = G1[10] xor G2[s1] xor G2[s2], tap pair per PRN from ICD table.
REQ-018 GLONASS: 9-stage LFSR 1+x^5+x^9, seeded GLO_INIT, chip = stage 7.
REQ-019 All outputs registered; on advance, chip/index outputs update in the cycle after detection and hold otherwise.
REQ-020 Index SHALL increment per advance and wrap 1022->0 (GPS) / 510->0 (GLONASS) together with LFSR reseed to exact initial state.
REQ-021 out_epoch_* SHALL pulse exactly one cycle coincident with index returning to 0 by wrap; never on reset or load.
REQ-022 Load with in_prn in 1..32: latch PRN, reseed G1/G2, GPS index 0, new PRN chip 0 visible next cycle; GLONASS unaffected.
REQ-023 Load with in_prn 0 or >32: PRN and state unchanged, out_prn_err pulses one cycle.
REQ-024 Load and GPS advance in same cycle: load wins, advance discarded.
REQ-025 GPS and GLONASS advances in same cycle SHALL both be applied independently.

Reset
REQ-026 in_reset SHALL, at any time including mid-code: reseed all LFSRs, indices 0, PRN = PRN_DEFAULT, edge samples 0, all pulse outputs 0, chip outputs = chip 0 of each sequence.
REQ-027 First advance after reset SHALL require a fresh 0->1 on the sampled chip clock.

Configuration
REQ-028 Macro PRN_GLONASS_EN: defined -> GLONASS generator present; undefined -> GLONASS logic removed, out_chip_GLONASS, out_idx_GLONASS, out_epoch_GLONASS tied 0, in_clock_GLONASS ignored.

Structure
REQ-029 Package prn_code_pkg SHALL hold code lengths (1023, 511), LFSR widths, seeds and the 32-entry G2 tap-pair table.
REQ-030 Sub-module prn_rise_det (sample register + rising-edge strobe) SHALL be instantiated once per chip clock.

Verification
REQ-031 Reset, PRN 1, GPS clock period 50 cycles -> first 10 chips 1100100000 (octal 1440).
REQ-032 Run 1023 GPS advances -> out_epoch_GPS exactly once at advance 1023, count 512 ones/511 zeros, index back to 0.
REQ-033 GLONASS clock period 25 cycles from reset -> chips 1-7 = 1, chip 8 = 0; epoch after 511 advances, 256 ones/255 zeros.
REQ-034 Load in_prn=0 then 33 -> out_prn_err pulses twice, GPS chip stream uninterrupted; load 5 coincident with advance -> index 0, advance dropped.
REQ-035 Assert in_reset at GPS index 700 -> next cycle index 0, PRN_DEFAULT, no epoch pulse.
REQ-036 Build without PRN_GLONASS_EN, toggle in_clock_GLONASS -> all GLONASS outputs stay 0.
